serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 129 ++++++++++++
 tb/tb_serial_adder.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder behind valid/ready load and result ports.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic             rdy_q;
  logic             h, s, cn;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    // two half-adder stages plus the carry register
    h  = a_q[0] ^ b_q[0];
    s  = h ^ c_q;
    cn = (a_q[0] & b_q[0]) | (h & c_q);
    unique case (state_q)
      IDLE: begin
        if (start_valid) begin
          a_d     = a_in;
          b_d     = b_in;
          c_d     = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        c_d   = cn;
        sum_d = (sum_q >> 1) | (WIDTH'(s) << (WIDTH - 1));
        if (cnt_q == LAST) begin
          state_d = DONE;
          cout_d  = cn;
`ifdef SERIAL_ADDER_OVF_EN
          ovf_d   = c_q ^ cn;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      rdy_q   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      rdy_q   <= (state_d == IDLE);
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign start_ready  = rdy_q;
  assign result_valid = (state_q == DONE);
  assign busy         = (state_q == RUN);
  assign sum_out      = sum_q;
  assign cout         = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf          = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Randomized bench for serial_adder (WIDTH=8 and WIDTH=1 instances)
// against an arithmetic reference model.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sv8 = 1'b0, sr8, rv8, rr8 = 1'b0, co8, bz8, ci8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, s8;
  logic       sv1 = 1'b0, sr1, rv1, rr1 = 1'b0, co1, bz1, ci1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0, s1;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ov8, ov1;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst),
    .start_valid(sv8), .start_ready(sr8),
    .a_in(a8), .b_in(b8), .cin(ci8),
    .result_valid(rv8), .result_ready(rr8),
    .sum_out(s8), .cout(co8),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf(ov8),
`endif
    .busy(bz8)
  );

  serial_adder #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst),
    .start_valid(sv1), .start_ready(sr1),
    .a_in(a1), .b_in(b1), .cin(ci1),
    .result_valid(rv1), .result_ready(rr1),
    .sum_out(s1), .cout(co1),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf(ov1),
`endif
    .busy(bz1)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready8();
    int n = 0;
    while (!sr8 && n < 50) begin
      step();
      n++;
    end
    check("ready_wait", {63'd0, sr8}, 64'd1);
  endtask

  // Issue one WIDTH=8 transaction; hold = cycles result_ready stays low in DONE.
  task automatic run8(input string tag, input logic [7:0] a,
                      input logic [7:0] b, input logic ci,
                      input int hold);
    logic [8:0] e;
    logic       eovf;
    logic [7:0] ss;
    logic       sc;
    int         n;
    e    = {1'b0, a} + {1'b0, b} + {8'd0, ci};
    eovf = (a[7] == b[7]) && (e[7] != a[7]);
    rr8  = (hold == 0);
    wait_ready8();
    sv8 = 1'b1; a8 = a; b8 = b; ci8 = ci;
    step();
    sv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
    check({tag, "_busy"}, {62'd0, bz8, sr8}, 64'd2);
    n = 0;
    while (!rv8 && n < 20) begin
      step();
      n++;
    end
    check({tag, "_lat"}, 64'(n), 64'd8);
    check({tag, "_sum"}, {55'd0, co8, s8}, {55'd0, e});
`ifdef SERIAL_ADDER_OVF_EN
    check({tag, "_ovf"}, {63'd0, ov8}, {63'd0, eovf});
`endif
    check({tag, "_done"}, {62'd0, bz8, sr8}, 64'd0);
    ss = s8;
    sc = co8;
    for (int i = 0; i < hold; i++) begin
      step();
      check({tag, "_hold"}, {53'd0, rv8, sr8, sc, ss},
            {53'd0, 1'b1, 1'b0, e[8], e[7:0]});
    end
    rr8 = 1'b1;
    step();
    check({tag, "_ack"}, {62'd0, rv8, sr8}, 64'd1);
    rr8 = 1'b0;
  endtask

  initial begin
    int n;
    step();
    step();
    check("rst_out", {53'd0, sr8, rv8, bz8, co8, s8}, 64'd0);
    rst = 1'b0;
    step();
    check("rst_ready", {62'd0, sr8, sr1}, 64'd3);

    run8("tp1", 8'h5A, 8'h3C, 1'b0, 0);
    run8("tp2", 8'hFF, 8'h01, 1'b0, 0);
    run8("tp3", 8'h7F, 8'h00, 1'b1, 0);
    run8("bp", 8'hA5, 8'hC3, 1'b1, 5);

    // reset on the third RUN cycle
    wait_ready8();
    sv8 = 1'b1; a8 = 8'h77; b8 = 8'h99; ci8 = 1'b1;
    step();
    sv8 = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    check("midrst", {53'd0, sr8, rv8, bz8, co8, s8}, 64'd0);
    rst = 1'b0;
    step();
    check("midrst_ready", {63'd0, sr8}, 64'd1);
    run8("post", 8'h01, 8'h01, 1'b0, 0);

    for (int i = 0; i < 40; i++)
      run8("rnd", 8'($urandom), 8'($urandom), 1'($urandom),
           int'($urandom_range(0, 3)));

    // WIDTH=1 instance
    rr1 = 1'b1;
    sv1 = 1'b1; a1 = 1'b1; b1 = 1'b1; ci1 = 1'b1;
    step();
    sv1 = 1'b0; a1 = 1'b0; b1 = 1'b0; ci1 = 1'b0;
    check("w1_busy", {62'd0, bz1, sr1}, 64'd2);
    n = 0;
    while (!rv1 && n < 10) begin
      step();
      n++;
    end
    check("w1_lat", 64'(n), 64'd1);
    check("w1_sum", {62'd0, co1, s1}, 64'd3);
`ifdef SERIAL_ADDER_OVF_EN
    check("w1_ovf", {63'd0, ov1}, 64'd0);
`endif
    step();
    check("w1_ack", {62'd0, rv1, sr1}, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
